// File: rtl/matrix_alu_if.sv
// matrix_alu_if: execution-engine bus into the matrix ALU window
interface matrix_alu_if;
   logic [15:0]  address;
   logic         nRead;
   logic         nWrite;
   logic [255:0] ExeDataOut;
   logic [255:0] MatrixDataOut;
   logic         Busy;
   logic         Complete;
   modport master (output address, nRead, nWrite, ExeDataOut, input MatrixDataOut, Busy, Complete);
   modport slave (input address, nRead, nWrite, ExeDataOut, output MatrixDataOut, Busy, Complete);
endinterface

// File: rtl/matrix_alu_responder.sv
// matrix_alu_responder: 4x4 matrix add/multiply target in the 16'h2xxx window
// MATRIX_SUB_EN enables lane-wise subtract on unit 2
module matrix_alu_responder #(
   parameter int ELEM_W = 16,
   parameter int DIM = 4,
   parameter logic [3:0] BASE_NIBBLE = 4'h2
) (
   input logic Clk,
   input logic Reset,
   matrix_alu_if.slave bus
);
   localparam int N = DIM * DIM;
   localparam int MW = N * ELEM_W;
   localparam int KW = $clog2(N);
`ifdef MATRIX_SUB_EN
   localparam bit SUB_EN = 1'b1;
`else
   localparam bit SUB_EN = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, ADD, SUB, MUL} state_t;
   state_t state, next;
   logic [MW-1:0] a, b, r, w, w_next, lane_sum, lane_diff;
   logic [KW-1:0] k;
   logic [ELEM_W-1:0] dot;
   logic [3:0] unit, regsel;
   logic sel, wr, rd, cmd;
   assign unit = bus.address[7:4];
   assign regsel = bus.address[3:0];
   assign sel = bus.address[15:12] == BASE_NIBBLE && (unit == 4'd0 || unit == 4'd1 || (SUB_EN && unit == 4'd2));
   assign wr = sel && !bus.nWrite && state == IDLE;
   assign rd = sel && !bus.nRead && bus.nWrite && regsel == 4'd2;
   assign cmd = wr && regsel == 4'd3;
   assign bus.Busy = state != IDLE;
   always_comb begin
      lane_sum = '0;
      lane_diff = '0;
      for (int i = 0; i < N; i++) begin
         lane_sum[i*ELEM_W +: ELEM_W] = a[i*ELEM_W +: ELEM_W] + b[i*ELEM_W +: ELEM_W];
         lane_diff[i*ELEM_W +: ELEM_W] = a[i*ELEM_W +: ELEM_W] - b[i*ELEM_W +: ELEM_W];
      end
   end
   // one output element per cycle: row k/DIM of A dotted with column k%DIM of B
   always_comb begin
      dot = '0;
      for (int j = 0; j < DIM; j++)
         dot = dot + ELEM_W'(a[ELEM_W*(DIM*(int'(k)/DIM)+j) +: ELEM_W] * b[ELEM_W*(DIM*j+int'(k)%DIM) +: ELEM_W]);
      w_next = w;
      w_next[ELEM_W*int'(k) +: ELEM_W] = dot;
   end
   always_ff @(posedge Clk)
      if (Reset) state <= IDLE;
      else state <= next;
   always_comb begin
      next = state;
      if (state == IDLE)
         next = !cmd ? IDLE : unit == 4'd0 ? MUL : unit == 4'd1 ? ADD : SUB;
      else if (state != MUL || k == KW'(N-1))
         next = IDLE;
   end
   always_ff @(posedge Clk) begin
      if (Reset) begin
         a <= '0;
         b <= '0;
         r <= '0;
         w <= '0;
         k <= '0;
         bus.MatrixDataOut <= '0;
         bus.Complete <= 1'b0;
      end else begin
         if (wr && regsel == 4'd0) a <= bus.ExeDataOut;
         if (wr && regsel == 4'd1) b <= bus.ExeDataOut;
         if (cmd) bus.Complete <= 1'b0;
         if (state == ADD || state == SUB) begin
            r <= state == ADD ? lane_sum : lane_diff;
            bus.Complete <= 1'b1;
         end
         if (state == MUL) begin
            w <= w_next;
            k <= k + 1'b1;
            if (k == KW'(N-1)) begin
               r <= w_next;
               bus.Complete <= 1'b1;
            end
         end
         if (rd) bus.MatrixDataOut <= r;
      end
   end
endmodule

// File: tb/tb_matrix_alu_responder.sv
// tb_matrix_alu_responder: directed vectors for the matrix ALU responder
module tb_matrix_alu_responder;
   logic Clk = 1'b0;
   logic Reset = 1'b1;
   matrix_alu_if bus();
   matrix_alu_responder dut (.Clk(Clk), .Reset(Reset), .bus(bus));
   always #5 Clk = ~Clk;
   int vectors = 0;
   int miscompares = 0;
   logic [255:0] ident, ascend;

   function automatic logic [255:0] fill(input logic [15:0] v);
      return {16{v}};
   endfunction

   task automatic bus_write(input logic [15:0] addr, input logic [255:0] data);
      @(negedge Clk);
      bus.address = addr;
      bus.ExeDataOut = data;
      bus.nWrite = 1'b0;
      @(negedge Clk);
      bus.nWrite = 1'b1;
   endtask

   task automatic bus_read(input logic [15:0] addr);
      @(negedge Clk);
      bus.address = addr;
      bus.nRead = 1'b0;
      @(negedge Clk);
      bus.nRead = 1'b1;
   endtask

   task automatic wait_idle(input int limit, output int cycles);
      cycles = 0;
      while (bus.Busy && cycles < limit) begin
         @(negedge Clk);
         cycles++;
      end
   endtask

   task automatic test_reset;
      Reset = 1'b1;
      bus.address = 16'h2003;
      bus.ExeDataOut = fill(16'h1234);
      bus.nWrite = 1'b0;
      bus.nRead = 1'b0;
      repeat (3) @(negedge Clk);
      vectors++;
      if (bus.MatrixDataOut !== '0) begin miscompares++; $display("FAIL reset_data got %h want 0", bus.MatrixDataOut); end
      vectors++;
      if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
      vectors++;
      if (bus.Complete !== 1'b0) begin miscompares++; $display("FAIL reset_complete got %b want 0", bus.Complete); end
      Reset = 1'b0;
      bus.nWrite = 1'b1;
      bus.nRead = 1'b1;
      bus_read(16'h2002);
      vectors++;
      if (bus.MatrixDataOut !== '0) begin miscompares++; $display("FAIL reset_read got %h want 0", bus.MatrixDataOut); end
   endtask

   task automatic test_unsupported;
      bus_write(16'h2033, '0);
      vectors++;
      if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL unsup_busy got %b want 0", bus.Busy); end
      vectors++;
      if (bus.Complete !== 1'b0) begin miscompares++; $display("FAIL unsup_complete got %b want 0", bus.Complete); end
   endtask

   task automatic test_add;
      bus_write(16'h2000, fill(16'h0001));
      bus_write(16'h2001, fill(16'h0002));
      bus_write(16'h2013, '0);
      vectors++;
      if (bus.Busy !== 1'b1) begin miscompares++; $display("FAIL add_busy got %b want 1", bus.Busy); end
      vectors++;
      if (bus.Complete !== 1'b0) begin miscompares++; $display("FAIL add_complete_early got %b want 0", bus.Complete); end
      @(negedge Clk);
      vectors++;
      if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL add_busy_done got %b want 0", bus.Busy); end
      vectors++;
      if (bus.Complete !== 1'b1) begin miscompares++; $display("FAIL add_complete got %b want 1", bus.Complete); end
      bus_read(16'h2012);
      vectors++;
      if (bus.MatrixDataOut !== fill(16'h0003)) begin miscompares++; $display("FAIL add_result got %h want %h", bus.MatrixDataOut, fill(16'h0003)); end
   endtask

   task automatic test_add_wrap;
      int c;
      bus_write(16'h2000, fill(16'hFFFF));
      bus_write(16'h2001, fill(16'h0002));
      bus_write(16'h2013, '0);
      wait_idle(4, c);
      bus_read(16'h2012);
      vectors++;
      if (bus.MatrixDataOut !== fill(16'h0001)) begin miscompares++; $display("FAIL add_wrap got %h want %h", bus.MatrixDataOut, fill(16'h0001)); end
   endtask

   task automatic test_mul_identity;
      int cycles;
      bus_write(16'h2000, ident);
      bus_write(16'h2001, ascend);
      @(negedge Clk);
      bus.address = 16'h2003;
      bus.nWrite = 1'b0;
      @(negedge Clk);
      vectors++;
      if (bus.Complete !== 1'b0) begin miscompares++; $display("FAIL mul_complete_clear got %b want 0", bus.Complete); end
      cycles = 0;
      while (bus.Busy && cycles < 40) begin
         cycles++;
         @(negedge Clk);
         bus.nWrite = 1'b1;
      end
      bus.nWrite = 1'b1;
      vectors++;
      if (cycles !== 16) begin miscompares++; $display("FAIL mul_busy_cycles got %0d want 16", cycles); end
      vectors++;
      if (bus.Complete !== 1'b1) begin miscompares++; $display("FAIL mul_complete got %b want 1", bus.Complete); end
      bus_read(16'h2002);
      vectors++;
      if (bus.MatrixDataOut !== ascend) begin miscompares++; $display("FAIL mul_identity got %h want %h", bus.MatrixDataOut, ascend); end
   endtask

   task automatic test_mul_dense;
      int c;
      bus_write(16'h2000, fill(16'h0002));
      bus_write(16'h2001, fill(16'h0003));
      bus_write(16'h2003, '0);
      bus_write(16'h2000, fill(16'h0007));
      bus_read(16'h2002);
      vectors++;
      if (bus.MatrixDataOut !== ascend) begin miscompares++; $display("FAIL busy_read got %h want %h", bus.MatrixDataOut, ascend); end
      wait_idle(40, c);
      vectors++;
      if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL dense_timeout busy got %b want 0", bus.Busy); end
      bus_read(16'h2002);
      vectors++;
      if (bus.MatrixDataOut !== fill(16'h0018)) begin miscompares++; $display("FAIL mul_dense got %h want %h", bus.MatrixDataOut, fill(16'h0018)); end
   endtask

   task automatic test_reset_mid_mul;
      bus_write(16'h2003, '0);
      repeat (7) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      vectors++;
      if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", bus.Busy); end
      vectors++;
      if (bus.Complete !== 1'b0) begin miscompares++; $display("FAIL abort_complete got %b want 0", bus.Complete); end
      bus_read(16'h2002);
      vectors++;
      if (bus.MatrixDataOut !== '0) begin miscompares++; $display("FAIL abort_read got %h want 0", bus.MatrixDataOut); end
   endtask

   task automatic test_sub;
      int c;
      bus_write(16'h2000, fill(16'h0005));
      bus_write(16'h2001, fill(16'h0007));
      bus_write(16'h2013, '0);
      wait_idle(4, c);
      bus_read(16'h2012);
      vectors++;
      if (bus.MatrixDataOut !== fill(16'h000C)) begin miscompares++; $display("FAIL pre_sub_add got %h want %h", bus.MatrixDataOut, fill(16'h000C)); end
      bus_write(16'h2023, '0);
`ifdef MATRIX_SUB_EN
      vectors++;
      if (bus.Busy !== 1'b1) begin miscompares++; $display("FAIL sub_busy got %b want 1", bus.Busy); end
      @(negedge Clk);
      vectors++;
      if (bus.Complete !== 1'b1) begin miscompares++; $display("FAIL sub_complete got %b want 1", bus.Complete); end
      bus_read(16'h2022);
      vectors++;
      if (bus.MatrixDataOut !== fill(16'hFFFE)) begin miscompares++; $display("FAIL sub_result got %h want %h", bus.MatrixDataOut, fill(16'hFFFE)); end
`else
      vectors++;
      if (bus.Busy !== 1'b0) begin miscompares++; $display("FAIL nosub_busy got %b want 0", bus.Busy); end
      vectors++;
      if (bus.Complete !== 1'b1) begin miscompares++; $display("FAIL nosub_complete got %b want 1", bus.Complete); end
      bus_read(16'h2022);
      vectors++;
      if (bus.MatrixDataOut !== fill(16'h000C)) begin miscompares++; $display("FAIL nosub_read got %h want %h", bus.MatrixDataOut, fill(16'h000C)); end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         ident[16*i +: 16] = (i / 4 == i % 4) ? 16'd1 : 16'd0;
         ascend[16*i +: 16] = 16'(i);
      end
      test_reset();
      test_unsupported();
      test_add();
      test_add_wrap();
      test_mul_identity();
      test_mul_dense();
      test_reset_mid_mul();
      test_sub();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
